// File: rtl/divider_pkg.sv
// Shared types and helpers for the sequential restoring divider.
package divider_pkg;

    typedef enum logic {
        IDLE = 1'b0,
        RUN  = 1'b1
    } state_t;

    // Widest operand the negate helper handles; callers cast in and truncate out.
    localparam int NEGATE_WIDTH = 64;

    localparam int DEFAULT_WORD_LENGTH = 16;

    function automatic int counter_width(input int word_length);
        return $clog2(word_length + 1);
    endfunction

    function automatic logic [NEGATE_WIDTH-1:0] cond_negate(
        input logic [NEGATE_WIDTH-1:0] value,
        input logic                    negate
    );
        return negate ? (~value + NEGATE_WIDTH'(1)) : value;
    endfunction

endpackage

// File: rtl/restoring_div_step.sv
// One restoring-division iteration: shift in the next dividend bit, trial subtract, restore on borrow.
module restoring_div_step #(
    parameter int WORD_LENGTH = 16
) (
    input  logic [2*WORD_LENGTH-1:0] partial_in,
    input  logic [WORD_LENGTH-1:0]   divisor,
    output logic [2*WORD_LENGTH-1:0] partial_out
);

    logic [2*WORD_LENGTH:0]   shifted;
    logic [WORD_LENGTH+1:0]   difference;
    logic                     quotient_bit;

    // Upper half holds the running remainder, lower half the unconsumed dividend bits
    // which are progressively replaced by quotient bits entering at bit 0.
    always_comb begin
        shifted      = {partial_in, 1'b0};
        difference   = {1'b0, shifted[2*WORD_LENGTH:WORD_LENGTH]} - {2'b00, divisor};
        quotient_bit = ~difference[WORD_LENGTH+1];
        if (quotient_bit) begin
            partial_out = {difference[WORD_LENGTH-1:0], shifted[WORD_LENGTH-1:1], 1'b1};
        end else begin
            partial_out = shifted[2*WORD_LENGTH-1:0];
        end
    end

endmodule

// File: rtl/seq_divider.sv
// Sequential signed/unsigned restoring divider, one quotient bit per clock, start/ready handshake.
module seq_divider
    import divider_pkg::*;
#(
    parameter int WORD_LENGTH    = DEFAULT_WORD_LENGTH,
    parameter int SIGNED_SUPPORT = 1
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic                   start,
    input  logic                   signed_mode,
    input  logic [WORD_LENGTH-1:0] dividend,
    input  logic [WORD_LENGTH-1:0] divisor,
    output logic [WORD_LENGTH-1:0] result,
    output logic [WORD_LENGTH-1:0] remainder,
    output logic                   busy,
    output logic                   ready,
    output logic                   div_by_zero,
    output logic                   overflow
);

    localparam int CNT_W = counter_width(WORD_LENGTH);

    state_t                     state;
    state_t                     next_state;
    logic [CNT_W-1:0]           count;
    logic [2*WORD_LENGTH-1:0]   partial;
    logic [2*WORD_LENGTH-1:0]   partial_next;
    logic [WORD_LENGTH-1:0]     divisor_mag;
    logic                       quotient_neg;
    logic                       remainder_neg;
    logic                       overflow_pending;

    logic                       use_signed;
    logic                       dividend_neg;
    logic                       divisor_neg;
    logic                       divisor_zero;
    logic                       accept;
    logic                       final_step;
    logic                       overflow_case;
    logic [WORD_LENGTH-1:0]     dividend_mag_in;
    logic [WORD_LENGTH-1:0]     divisor_mag_in;
    logic [WORD_LENGTH-1:0]     result_final;
    logic [WORD_LENGTH-1:0]     remainder_final;

    restoring_div_step #(
        .WORD_LENGTH(WORD_LENGTH)
    ) u_step (
        .partial_in  (partial),
        .divisor     (divisor_mag),
        .partial_out (partial_next)
    );

    always_comb begin
        use_signed      = (SIGNED_SUPPORT != 0) && signed_mode;
        dividend_neg    = use_signed && dividend[WORD_LENGTH-1];
        divisor_neg     = use_signed && divisor[WORD_LENGTH-1];
        divisor_zero    = (divisor == '0);
        accept          = (state == IDLE) && start;
        final_step      = (state == RUN) && (count == CNT_W'(1));
        overflow_case   = use_signed
                          && (dividend == {1'b1, {(WORD_LENGTH-1){1'b0}}})
                          && (divisor == '1);
        dividend_mag_in = WORD_LENGTH'(cond_negate(NEGATE_WIDTH'(dividend), dividend_neg));
        divisor_mag_in  = WORD_LENGTH'(cond_negate(NEGATE_WIDTH'(divisor), divisor_neg));
        result_final    = WORD_LENGTH'(cond_negate(
                              NEGATE_WIDTH'(partial_next[WORD_LENGTH-1:0]), quotient_neg));
        remainder_final = WORD_LENGTH'(cond_negate(
                              NEGATE_WIDTH'(partial_next[2*WORD_LENGTH-1:WORD_LENGTH]), remainder_neg));
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state <= IDLE;
        end else begin
            state <= next_state;
        end
    end

    // Divide-by-zero is resolved at accept and never enters RUN.
    always_comb begin
        next_state = state;
        case (state)
            IDLE: if (accept && !divisor_zero) next_state = RUN;
            RUN:  if (final_step)              next_state = IDLE;
            default: next_state = IDLE;
        endcase
    end

    always_comb begin
        busy = (state == RUN);
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            count            <= '0;
            partial          <= '0;
            divisor_mag      <= '0;
            quotient_neg     <= 1'b0;
            remainder_neg    <= 1'b0;
            overflow_pending <= 1'b0;
            result           <= '0;
            remainder        <= '0;
            ready            <= 1'b0;
            div_by_zero      <= 1'b0;
            overflow         <= 1'b0;
        end else begin
            ready <= 1'b0;
            if (accept) begin
                if (divisor_zero) begin
                    result      <= '1;
                    remainder   <= dividend;
                    div_by_zero <= 1'b1;
                    overflow    <= 1'b0;
                    ready       <= 1'b1;
                end else begin
                    partial          <= {{WORD_LENGTH{1'b0}}, dividend_mag_in};
                    divisor_mag      <= divisor_mag_in;
                    quotient_neg     <= dividend_neg ^ divisor_neg;
                    remainder_neg    <= dividend_neg;
                    overflow_pending <= overflow_case;
                    count            <= CNT_W'(WORD_LENGTH);
                end
            end else if (state == RUN) begin
                partial <= partial_next;
                count   <= count - CNT_W'(1);
                if (final_step) begin
                    result      <= result_final;
                    remainder   <= remainder_final;
                    div_by_zero <= 1'b0;
                    overflow    <= overflow_pending;
                    ready       <= 1'b1;
                end
            end
        end
    end

endmodule

// File: tb/tb_seq_divider.sv
// Scoreboard bench for seq_divider: driver pushes reference results, monitor pops on ready.
module tb_seq_divider;

    localparam int W = 16;

    typedef struct {
        logic [W-1:0] result;
        logic [W-1:0] remainder;
        logic         dbz;
        logic         ovf;
        int           ready_cycle;
    } exp_t;

    logic         clk = 1'b0;
    logic         reset = 1'b0;
    logic         start = 1'b0;
    logic         signed_mode = 1'b0;
    logic [W-1:0] dividend = '0;
    logic [W-1:0] divisor = '0;
    logic [W-1:0] result;
    logic [W-1:0] remainder;
    logic         busy;
    logic         ready;
    logic         div_by_zero;
    logic         overflow;

    int   errors = 0;
    int   checks = 0;
    int   cycle = 0;
    exp_t scoreboard[$];
    exp_t mon_e;

    seq_divider #(
        .WORD_LENGTH(W),
        .SIGNED_SUPPORT(1)
    ) dut (
        .clk         (clk),
        .reset       (reset),
        .start       (start),
        .signed_mode (signed_mode),
        .dividend    (dividend),
        .divisor     (divisor),
        .result      (result),
        .remainder   (remainder),
        .busy        (busy),
        .ready       (ready),
        .div_by_zero (div_by_zero),
        .overflow    (overflow)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cycle <= cycle + 1;

    task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
        checks++;
        if (actual !== expected) begin
            errors++;
            $display("[TB] FAIL %s: got %h, expected %h (cycle %0d)", name, actual, expected, cycle);
        end
    endtask

    // Reference model from plain integer arithmetic.
    function automatic exp_t model(input logic [W-1:0] a, input logic [W-1:0] b, input logic sm);
        exp_t e;
        int   q;
        int   r;
        e.ovf = 1'b0;
        e.dbz = 1'b0;
        if (b == '0) begin
            e.result    = '1;
            e.remainder = a;
            e.dbz       = 1'b1;
        end else if (sm) begin
            int sa = $signed(a);
            int sd = $signed(b);
            q = sa / sd;
            r = sa % sd;
            e.result    = q[W-1:0];
            e.remainder = r[W-1:0];
            e.ovf       = (q > 32767);
        end else begin
            int ua = int'(a);
            int ud = int'(b);
            q = ua / ud;
            r = ua % ud;
            e.result    = q[W-1:0];
            e.remainder = r[W-1:0];
        end
        e.ready_cycle = 0;
        return e;
    endfunction

    // Monitor: every ready pulse must match the oldest outstanding request.
    always @(negedge clk) begin
        if (ready) begin
            if (scoreboard.size() == 0) begin
                checkOutput("unexpected_ready", 32'(ready), 32'(0));
            end else begin
                mon_e = scoreboard.pop_front();
                checkOutput("result",      32'(result),      32'(mon_e.result));
                checkOutput("remainder",   32'(remainder),   32'(mon_e.remainder));
                checkOutput("div_by_zero", 32'(div_by_zero), 32'(mon_e.dbz));
                checkOutput("overflow",    32'(overflow),    32'(mon_e.ovf));
                checkOutput("ready_cycle", 32'(cycle),       32'(mon_e.ready_cycle));
                checkOutput("busy_at_ready", 32'(busy),      32'(0));
            end
        end
    end

    // Called at a negedge with the divider idle; returns one negedge after the accept edge.
    task automatic applyStimulus(input logic [W-1:0] a, input logic [W-1:0] b, input logic sm);
        exp_t e;
        dividend    = a;
        divisor     = b;
        signed_mode = sm;
        start       = 1'b1;
        e = model(a, b, sm);
        e.ready_cycle = cycle + 1 + ((b == '0) ? 0 : W);
        scoreboard.push_back(e);
        @(negedge clk);
        start       = 1'b0;
        dividend    = 16'($urandom);
        divisor     = 16'($urandom);
        signed_mode = 1'($urandom);
        checkOutput("busy_after_accept", 32'(busy), 32'(b != '0));
    endtask

    task automatic waitDone();
        for (int i = 0; i < 40 && scoreboard.size() != 0; i++) @(negedge clk);
        checkOutput("completion_timeout", 32'(scoreboard.size()), 32'(0));
        scoreboard.delete();
        @(negedge clk);
    endtask

    task automatic waitReady();
        int n = 0;
        while (!ready && n < 40) begin
            @(negedge clk);
            n++;
        end
        checkOutput("ready_timeout", 32'(ready), 32'(1));
    endtask

    task automatic pulseIgnoredStart(input int delay);
        repeat (delay) @(negedge clk);
        dividend    = 16'h0005;
        divisor     = 16'h0001;
        signed_mode = 1'b1;
        start       = 1'b1;
        @(negedge clk);
        start = 1'b0;
    endtask

    task automatic checkResetValues(input string tag);
        checkOutput({tag, "_result"},      32'(result),      32'(0));
        checkOutput({tag, "_remainder"},   32'(remainder),   32'(0));
        checkOutput({tag, "_busy"},        32'(busy),        32'(0));
        checkOutput({tag, "_ready"},       32'(ready),       32'(0));
        checkOutput({tag, "_div_by_zero"}, 32'(div_by_zero), 32'(0));
        checkOutput({tag, "_overflow"},    32'(overflow),    32'(0));
    endtask

    initial begin
        logic [W-1:0] ra;
        logic [W-1:0] rb;
        logic         rs;

        #1;
        checkResetValues("reset");
        repeat (3) @(negedge clk);
        reset = 1'b1;
        @(negedge clk);

        applyStimulus(16'd100, 16'd7, 1'b0);
        waitDone();
        applyStimulus(16'hFF9C, 16'd7, 1'b1);
        waitDone();
        applyStimulus(16'd100, 16'hFFF9, 1'b1);
        waitDone();
        applyStimulus(16'h1234, 16'h0000, 1'b0);
        waitDone();
        applyStimulus(16'h8000, 16'hFFFF, 1'b1);
        waitDone();
        applyStimulus(16'h8000, 16'hFFFF, 1'b0);
        waitDone();

        applyStimulus(16'd1000, 16'd3, 1'b0);
        pulseIgnoredStart(5);
        waitDone();

        applyStimulus(16'd5000, 16'd9, 1'b0);
        waitReady();
        applyStimulus(16'hEC78, 16'd13, 1'b1);
        waitDone();

        for (int i = 0; i < 30; i++) begin
            ra = 16'($urandom);
            rb = ($urandom_range(0, 7) == 0) ? 16'h0000 :
                 ($urandom_range(0, 1) == 0) ? 16'($urandom_range(1, 40)) : 16'($urandom);
            if ($urandom_range(0, 9) == 0) begin
                ra = 16'h8000;
                rb = 16'hFFFF;
            end
            rs = 1'($urandom);
            applyStimulus(ra, rb, rs);
            waitDone();
        end

        applyStimulus(16'd4321, 16'd5, 1'b0);
        repeat (7) @(negedge clk);
        reset = 1'b0;
        scoreboard.delete();
        #1;
        checkResetValues("midrun_reset");
        repeat (3) @(negedge clk);
        reset = 1'b1;
        repeat (2) @(negedge clk);
        checkResetValues("after_release");

        applyStimulus(16'd65535, 16'd255, 1'b0);
        waitDone();
        applyStimulus(16'h8001, 16'h0003, 1'b1);
        waitDone();

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #200000;
        $display("[TB] FAIL global_timeout: simulation did not finish");
        $fatal(1, "[TB] timeout");
    end

endmodule

// File: doc/seq_divider.md
# seq_divider

Parametrised sequential restoring divider with a start/ready handshake, selectable signed/unsigned mode, divide-by-zero and overflow detection. It produces one quotient bit per clock and holds the last result until the next operation completes. It is the general-purpose divide unit for the datapath, replacing the free-running fixed-width divider.

## Interface
- WORD_LENGTH, 16, operand/result width in bits (≥ 4)
- SIGNED_SUPPORT, 1, 1 enables `signed_mode`; 0 ties signed mode off internally
- clk  input  1  rising-edge clock
- reset  input  1  asynchronous, active-low reset
- start  input  1  request; sampled only while `busy`=0
- signed_mode  input  1  1 = two's-complement operands, 0 = unsigned; captured with `start`
- dividend  input  WORD_LENGTH  captured with `start`
- divisor  input  WORD_LENGTH  captured with `start`
- result  output  WORD_LENGTH  quotient, registered, held until next completion
- remainder  output  WORD_LENGTH  remainder, registered, held until next completion
- busy  output  1  high from the edge after accept until completion
- ready  output  1  one-cycle pulse: `result`/`remainder`/flags valid and updated
- div_by_zero  output  1  registered status of the last completed operation
- overflow  output  1  registered status of the last completed operation

## Operation
- States: IDLE, RUN. Reset → IDLE.
- IDLE: `start`=1 at an edge → accept. Capture mode and operand magnitudes (negate negative operands when signed), record quotient sign (sign XOR) and remainder sign (dividend sign), load iteration counter = WORD_LENGTH, enter RUN.
- Accept with divisor = 0: no RUN. Write result = all ones, remainder = dividend (unmodified), div_by_zero=1, overflow=0, ready=1 next cycle, stay IDLE.
- RUN step: partial remainder (2·WORD_LENGTH wide) shifted left with next dividend bit, trial subtract divisor; non-negative → keep difference, quotient bit 1; negative → restore, bit 0. Counter decrements.
- Final step (counter = 1): apply sign correction (negate quotient if quotient sign set, negate remainder if remainder sign set), write output registers, div_by_zero=0, overflow per below, pulse ready, return IDLE.
- Signed semantics: quotient truncates toward zero; remainder takes the dividend's sign; dividend = result·divisor + remainder always holds.
- Overflow: signed, dividend = −2^(WORD_LENGTH−1), divisor = −1 → result = −2^(WORD_LENGTH−1) (wrapped), remainder = 0, overflow=1. Goes through normal RUN timing.
- Unsigned mode: no correction, overflow always 0.
- `start` while busy: ignored, no effect on operation or outputs.

## Timing
- Reset values: result=0, remainder=0, busy=0, ready=0, div_by_zero=0, overflow=0; state IDLE, counter 0.
- Normal latency: accept at edge N → busy=1 after edge N, ready=1 for exactly the cycle after edge N+WORD_LENGTH, busy=0 in that same cycle.
- Divide-by-zero latency: ready=1 for the cycle after edge N; busy stays 0.
- Back-to-back: `start` asserted in the ready cycle is accepted (state is IDLE); previous outputs persist until the new completion.
- Reset asserted mid-RUN: immediate abort, all outputs return to reset values, no ready pulse.
- Operand inputs are don't-care except at the accept edge.

## Structure
- Package `divider_pkg`: state enum typedef (IDLE, RUN); localparam for counter width = $clog2(WORD_LENGTH+1); helper function for conditional two's-complement negate.
- One sub-module: `restoring_div_step` (combinational: shift, trial subtract, restore mux, quotient bit), parametrised by WORD_LENGTH.
- FSM, counter, operand/sign registers and output registers live in `seq_divider`.

## Test plan (WORD_LENGTH=16)
- Unsigned 100 / 7 → result 14, remainder 2, ready exactly 16 cycles after the accept edge, one cycle wide.
- Signed −100 / 7 → result 0xFFF2 (−14), remainder 0xFFFE (−2); signed 100 / −7 → 0xFFF2, 2.
- Divisor 0, dividend 0x1234 → result 0xFFFF, remainder 0x1234, div_by_zero=1, ready the cycle after accept, busy never high.
- Signed 0x8000 / 0xFFFF → result 0x8000, remainder 0, overflow=1; same operands unsigned → result 0, remainder 0x8000, overflow=0.
- `start` pulsed mid-RUN with different operands → ignored, first result correct; `start` during ready cycle → second operation accepted, completes 16 cycles later.
- Reset low at cycle 8 of RUN → all outputs 0, no ready pulse; next operation after release completes correctly.
